// File: rtl/multicycle_controller.sv
// multicycle_controller
// Control FSM for a multi-cycle RV32I core with a shared ALU. Each instruction
// passes through FETCH/DECODE/EXEC/MEM/WB. The block drives the datapath
// enables and mux selects, handles wait-state memory, and checks a memory
// watchdog. A sticky trap state is entered on an illegal encoding or a memory
// timeout.
//
// Ports:
//   clk, rst_n       - rising-edge clock, asynchronous active-low reset
//   inst             - instruction register contents (valid from DECODE on)
//   zero             - ALU zero flag
//   mem_ready        - memory completes the current access this cycle
//   mem_req/mem_we   - memory request / write strobe
//   mem_addr_sel     - memory address source (0 PC, 1 ALUOut)
//   ir_write         - load IR and OldPC
//   pc_write/pc_src  - PC write enable / next-PC source
//   alu_src_a/_b     - ALU operand selects
//   alu_op           - ALU operation class
//   reg_write/wb_sel - register-file write enable / write-back source
//   retire           - one-cycle pulse in the final cycle of each instruction
//   trap/trap_cause  - sticky trap flag and its cause
//   state_o          - current state encoding, for debug
module multicycle_controller #(
  parameter int BRANCH_BNE     = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  // beq and bne get separate classes so EXEC needs no further decode of inst.
  typedef enum logic [2:0] {
    CL_R     = 3'd0,
    CL_I     = 3'd1,
    CL_LOAD  = 3'd2,
    CL_STORE = 3'd3,
    CL_BEQ   = 3'd4,
    CL_BNE   = 3'd5,
    CL_JAL   = 3'd6,
    CL_JALR  = 3'd7
  } cls_t;

  // The width is kept at least 1 so the watchdog-disabled build still elaborates.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_t        state_r;
  cls_t          cls_r;
  logic [CW-1:0] wd_cnt_r;
  logic [1:0]    trap_cause_r;
  logic [3:0]    dec_s;
  logic          wd_expire_s;
  logic          unused_inst_s;

  // Returns {legal, class}; only opcode and funct3 take part in the decode.
  function automatic logic [3:0] decode_class(input logic [6:0] opc, input logic [2:0] f3);
    logic [3:0] r;
    r = 4'b0000;
    case (opc)
      7'b0110011: r = {1'b1, CL_R};
      7'b0010011: r = {1'b1, CL_I};
      7'b0000011: r = {1'b1, CL_LOAD};
      7'b0100011: r = {1'b1, CL_STORE};
      7'b1101111: r = {1'b1, CL_JAL};
      7'b1100111: r = {1'b1, CL_JALR};
      7'b1100011: begin
        if (f3 == 3'b000) begin
          r = {1'b1, CL_BEQ};
        end else if ((BRANCH_BNE != 0) && (f3 == 3'b001)) begin
          r = {1'b1, CL_BNE};
        end else begin
          r = 4'b0000;
        end
      end
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  assign unused_inst_s = ^{inst[31:15], inst[11:7]};

  // Class decode and watchdog expiry, both consumed by the state register.
  always_comb begin
    dec_s       = decode_class(inst[6:0], inst[14:12]);
    // Expiry happens on the TIMEOUT_CYCLES-th low cycle; a ready on that cycle wins.
    wd_expire_s = (TIMEOUT_CYCLES > 0) && !mem_ready && (wd_cnt_r == WD_LAST);
  end

  // State, latched class, watchdog counter and trap cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_RST;
      cls_r        <= CL_R;
      wd_cnt_r     <= '0;
      trap_cause_r <= 2'b00;
    end else begin
      // The counter is zero outside FETCH/MEM, so every entry starts it from zero.
      if ((TIMEOUT_CYCLES > 0) && ((state_r == ST_FETCH) || (state_r == ST_MEM)) && !mem_ready) begin
        wd_cnt_r <= wd_cnt_r + CW'(1);
      end else begin
        wd_cnt_r <= '0;
      end

      case (state_r)
        ST_RST: state_r <= ST_FETCH;
        ST_FETCH: begin
          if (mem_ready) begin
            state_r <= ST_DECODE;
          end else if (wd_expire_s) begin
            state_r      <= ST_TRAP;
            trap_cause_r <= 2'b10;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_DECODE: begin
          if (dec_s[3]) begin
            cls_r   <= cls_t'(dec_s[2:0]);
            state_r <= ST_EXEC;
          end else begin
            state_r      <= ST_TRAP;
            trap_cause_r <= 2'b01;
          end
        end
        ST_EXEC: begin
          case (cls_r)
            CL_BEQ, CL_BNE:    state_r <= ST_FETCH;
            CL_LOAD, CL_STORE: state_r <= ST_MEM;
            default:           state_r <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (mem_ready) begin
            state_r <= (cls_r == CL_STORE) ? ST_FETCH : ST_WB;
          end else if (wd_expire_s) begin
            state_r      <= ST_TRAP;
            trap_cause_r <= 2'b10;
          end else begin
            state_r <= ST_MEM;
          end
        end
        ST_WB:   state_r <= ST_FETCH;
        ST_TRAP: state_r <= ST_TRAP;
        default: state_r <= ST_RST;
      endcase
    end
  end

  // Datapath controls from state and latched class; anything unlisted stays 0.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    reg_write    = 1'b0;
    wb_sel       = 2'b00;
    retire       = 1'b0;
    trap         = 1'b0;
    case (state_r)
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      ST_EXEC: begin
        case (cls_r)
          CL_R: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
          end
          CL_I: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b10;
            alu_op    = 2'b11;
          end
          CL_LOAD, CL_STORE: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b10;
          end
          CL_BEQ, CL_BNE: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            pc_src    = 2'b01;
            pc_write  = (cls_r == CL_BNE) ? !zero : zero;
            retire    = 1'b1;
          end
          CL_JAL: begin
            pc_write = 1'b1;
            pc_src   = 2'b01;
          end
          CL_JALR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
            pc_src    = 2'b10;
          end
          default: begin
            pc_write = 1'b0;
          end
        endcase
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls_r == CL_STORE);
        retire       = (cls_r == CL_STORE) && mem_ready;
      end
      ST_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        if (cls_r == CL_LOAD) begin
          wb_sel = 2'b01;
        end else if ((cls_r == CL_JAL) || (cls_r == CL_JALR)) begin
          wb_sel = 2'b10;
        end else begin
          wb_sel = 2'b00;
        end
      end
      ST_TRAP: trap = 1'b1;
      default: trap = 1'b0;
    endcase
  end

  assign trap_cause = trap_cause_r;
  assign state_o    = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller. The driver pushes one expected
// output vector per cycle; a negedge monitor pops and compares it against the
// DUT. dut0 uses BRANCH_BNE=1, TIMEOUT_CYCLES=4 and dut1 uses BRANCH_BNE=0.
module tb_multicycle_controller;

  logic clk;
  logic rst_n0, mem_ready0, zero0;
  logic rst_n1, mem_ready1, zero1;
  logic [31:0] inst0, inst1;

  logic mem_req0, mem_we0, mem_addr_sel0, ir_write0, pc_write0, reg_write0, retire0, trap0;
  logic [1:0] pc_src0, alu_src_a0, alu_src_b0, alu_op0, wb_sel0, trap_cause0;
  logic [2:0] state_o0;
  logic mem_req1, mem_we1, mem_addr_sel1, ir_write1, pc_write1, reg_write1, retire1, trap1;
  logic [1:0] pc_src1, alu_src_a1, alu_src_b1, alu_op1, wb_sel1, trap_cause1;
  logic [2:0] state_o1;

  logic [22:0] q0[$];
  logic [22:0] q1[$];
  int t0[$];
  int t1[$];
  int tnum;
  int total_cnt;
  int pass_cnt;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_BNE  = 32'h00209063;
  localparam logic [31:0] I_JAL  = 32'h0000006F;
  localparam logic [31:0] I_JALR = 32'h00008067;
  localparam logic [31:0] I_ADDI = 32'h00108093;

  multicycle_controller #(.BRANCH_BNE(1), .TIMEOUT_CYCLES(4)) dut0 (
    .clk(clk), .rst_n(rst_n0), .inst(inst0), .zero(zero0), .mem_ready(mem_ready0),
    .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr_sel(mem_addr_sel0),
    .ir_write(ir_write0), .pc_write(pc_write0), .pc_src(pc_src0),
    .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .alu_op(alu_op0),
    .reg_write(reg_write0), .wb_sel(wb_sel0), .retire(retire0), .trap(trap0),
    .trap_cause(trap_cause0), .state_o(state_o0)
  );

  multicycle_controller #(.BRANCH_BNE(0), .TIMEOUT_CYCLES(4)) dut1 (
    .clk(clk), .rst_n(rst_n1), .inst(inst1), .zero(zero1), .mem_ready(mem_ready1),
    .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr_sel(mem_addr_sel1),
    .ir_write(ir_write1), .pc_write(pc_write1), .pc_src(pc_src1),
    .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .alu_op(alu_op1),
    .reg_write(reg_write1), .wb_sel(wb_sel1), .retire(retire1), .trap(trap1),
    .trap_cause(trap_cause1), .state_o(state_o1)
  );

  logic [22:0] act0, act1;
  assign act0 = {state_o0, mem_req0, mem_we0, mem_addr_sel0, ir_write0, pc_write0, pc_src0,
                 alu_src_a0, alu_src_b0, alu_op0, reg_write0, wb_sel0, retire0, trap0, trap_cause0};
  assign act1 = {state_o1, mem_req1, mem_we1, mem_addr_sel1, ir_write1, pc_write1, pc_src1,
                 alu_src_a1, alu_src_b1, alu_op1, reg_write1, wb_sel1, retire1, trap1, trap_cause1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Field packing: {state, req, we, asel, irw, pcw, pcs, srca, srcb, op, rw, wbs, ret, trap, cause}
  function automatic logic [22:0] ov(input logic [2:0] st, input logic req, input logic we,
                                     input logic asel, input logic irw, input logic pcw,
                                     input logic [1:0] pcs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] op,
                                     input logic rw, input logic [1:0] wbs, input logic ret,
                                     input logic trp, input logic [1:0] tc);
    return {st, req, we, asel, irw, pcw, pcs, sa, sb, op, rw, wbs, ret, trp, tc};
  endfunction

  function automatic logic [22:0] f_rst();
    return 23'h0;
  endfunction
  function automatic logic [22:0] f_fetch(input logic r);
    return ov(3'd1, 1'b1, 1'b0, 1'b0, r, r, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
  endfunction
  function automatic logic [22:0] f_dec();
    return ov(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
  endfunction
  function automatic logic [22:0] f_ex(input logic pcw, input logic [1:0] pcs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] op, input logic ret);
    return ov(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, pcw, pcs, sa, sb, op, 1'b0, 2'b00, ret, 1'b0, 2'b00);
  endfunction
  function automatic logic [22:0] f_mem(input logic st, input logic r);
    return ov(3'd4, 1'b1, st, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, st & r, 1'b0, 2'b00);
  endfunction
  function automatic logic [22:0] f_wb(input logic [1:0] w);
    return ov(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, w, 1'b1, 1'b0, 2'b00);
  endfunction
  function automatic logic [22:0] f_trap(input logic [1:0] c);
    return ov(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, c);
  endfunction

  // One cycle: drive inputs just after the edge and queue that cycle's expectation.
  task automatic step(input int d, input logic rst, input logic rdy, input logic z, input logic [22:0] e);
    @(posedge clk);
    #1;
    if (d == 0) begin
      rst_n0 = rst; mem_ready0 = rdy; zero0 = z;
      q0.push_back(e); t0.push_back(tnum);
    end else begin
      rst_n1 = rst; mem_ready1 = rdy; zero1 = z;
      q1.push_back(e); t1.push_back(tnum);
    end
  endtask

  // Monitor: compare every queued expectation mid-cycle.
  always @(negedge clk) begin
    logic [22:0] e;
    int t;
    if (q0.size() > 0) begin
      e = q0.pop_front(); t = t0.pop_front();
      total_cnt++;
      if (act0 === e) pass_cnt++;
      else $display("FAIL dut0 test%0d outputs: got %h want %h", t, act0, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front(); t = t1.pop_front();
      total_cnt++;
      if (act1 === e) pass_cnt++;
      else $display("FAIL dut1 test%0d outputs: got %h want %h", t, act1, e);
    end
  end

  initial begin
    total_cnt = 0; pass_cnt = 0; tnum = 0;
    rst_n0 = 1'b0; mem_ready0 = 1'b0; zero0 = 1'b0; inst0 = I_ADD;
    rst_n1 = 1'b0; mem_ready1 = 1'b0; zero1 = 1'b0; inst1 = I_BNE;

    // 1: reset, then add -> states 0,1,2,3,5,1
    tnum = 1;
    step(0, 1'b0, 1'b1, 1'b0, f_rst());
    step(0, 1'b1, 1'b1, 1'b0, f_rst());
    step(0, 1'b1, 1'b1, 1'b0, f_fetch(1'b1));
    step(0, 1'b1, 1'b1, 1'b0, f_dec());
    step(0, 1'b1, 1'b1, 1'b0, f_ex(1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0));
    step(0, 1'b1, 1'b1, 1'b0, f_wb(2'b00));

    // 2: lw with three MEM wait cycles -> 8 cycles
    tnum = 2; inst0 = I_LW;
    step(0, 1'b1, 1'b1, 1'b0, f_fetch(1'b1));
    step(0, 1'b1, 1'b1, 1'b0, f_dec());
    step(0, 1'b1, 1'b1, 1'b0, f_ex(1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0));
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b0, 1'b0, f_mem(1'b0, 1'b0));
    step(0, 1'b1, 1'b1, 1'b0, f_mem(1'b0, 1'b1));
    step(0, 1'b1, 1'b1, 1'b0, f_wb(2'b01));

    // 3: sw, zero wait
    tnum = 3; inst0 = I_SW;
    step(0, 1'b1, 1'b1, 1'b0, f_fetch(1'b1));
    step(0, 1'b1, 1'b1, 1'b0, f_dec());
    step(0, 1'b1, 1'b1, 1'b0, f_ex(1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0));
    step(0, 1'b1, 1'b1, 1'b0, f_mem(1'b1, 1'b1));

    // 4: beq taken / not taken, bne zero=1 / zero=0
    tnum = 4; inst0 = I_BEQ;
    step(0, 1'b1, 1'b1, 1'b0, f_fetch(1'b1));
    step(0, 1'b1, 1'b1, 1'b0, f_dec());
    step(0, 1'b1, 1'b1, 1'b1, f_ex(1'b1, 2'b01, 2'b10, 2'b00, 2'b01, 1'b1));
    step(0, 1'b1, 1'b1, 1'b0, f_fetch(1'b1));
    step(0, 1'b1, 1'b1, 1'b0, f_dec());
    step(0, 1'b1, 1'b1, 1'b0, f_ex(1'b0, 2'b01, 2'b10, 2'b00, 2'b01, 1'b1));
    tnum = 5; inst0 = I_BNE;
    step(0, 1'b1, 1'b1, 1'b0, f_fetch(1'b1));
    step(0, 1'b1, 1'b1, 1'b0, f_dec());
    step(0, 1'b1, 1'b1, 1'b1, f_ex(1'b0, 2'b01, 2'b10, 2'b00, 2'b01, 1'b1));
    step(0, 1'b1, 1'b1, 1'b0, f_fetch(1'b1));
    step(0, 1'b1, 1'b1, 1'b0, f_dec());
    step(0, 1'b1, 1'b1, 1'b0, f_ex(1'b1, 2'b01, 2'b10, 2'b00, 2'b01, 1'b1));

    // 6: jal, jalr, addi
    tnum = 6; inst0 = I_JAL;
    step(0, 1'b1, 1'b1, 1'b0, f_fetch(1'b1));
    step(0, 1'b1, 1'b1, 1'b0, f_dec());
    step(0, 1'b1, 1'b1, 1'b0, f_ex(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0));
    step(0, 1'b1, 1'b1, 1'b0, f_wb(2'b10));
    tnum = 7; inst0 = I_JALR;
    step(0, 1'b1, 1'b1, 1'b0, f_fetch(1'b1));
    step(0, 1'b1, 1'b1, 1'b0, f_dec());
    step(0, 1'b1, 1'b1, 1'b0, f_ex(1'b1, 2'b10, 2'b10, 2'b10, 2'b00, 1'b0));
    step(0, 1'b1, 1'b1, 1'b0, f_wb(2'b10));
    tnum = 8; inst0 = I_ADDI;
    step(0, 1'b1, 1'b1, 1'b0, f_fetch(1'b1));
    step(0, 1'b1, 1'b1, 1'b0, f_dec());
    step(0, 1'b1, 1'b1, 1'b0, f_ex(1'b0, 2'b00, 2'b10, 2'b10, 2'b11, 1'b0));
    step(0, 1'b1, 1'b1, 1'b0, f_wb(2'b00));

    // 9: ready arrives on the 4th fetch cycle -> no trap; ready ignored outside FETCH/MEM
    tnum = 9; inst0 = I_ADD;
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b0, 1'b0, f_fetch(1'b0));
    step(0, 1'b1, 1'b1, 1'b0, f_fetch(1'b1));
    step(0, 1'b1, 1'b0, 1'b0, f_dec());
    step(0, 1'b1, 1'b0, 1'b0, f_ex(1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0));
    step(0, 1'b1, 1'b0, 1'b0, f_wb(2'b00));

    // 10: ready stuck low in FETCH -> TRAP after exactly 4 cycles, cause 10
    tnum = 10;
    for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, 1'b0, f_fetch(1'b0));
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b1, 1'b0, f_trap(2'b10));
    step(0, 1'b0, 1'b1, 1'b0, f_rst());
    step(0, 1'b1, 1'b1, 1'b0, f_rst());

    // 11: illegal opcode -> TRAP cause 01 held 100 cycles, then reset recovery
    tnum = 11; inst0 = 32'h00000000;
    step(0, 1'b1, 1'b1, 1'b0, f_fetch(1'b1));
    step(0, 1'b1, 1'b1, 1'b0, f_dec());
    for (int i = 0; i < 100; i++) step(0, 1'b1, 1'b1, 1'b0, f_trap(2'b01));
    tnum = 12;
    step(0, 1'b0, 1'b1, 1'b0, f_rst());
    step(0, 1'b1, 1'b1, 1'b0, f_rst());
    inst0 = I_ADD;
    step(0, 1'b1, 1'b1, 1'b0, f_fetch(1'b1));
    step(0, 1'b1, 1'b1, 1'b0, f_dec());
    step(0, 1'b1, 1'b1, 1'b0, f_ex(1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0));
    step(0, 1'b1, 1'b1, 1'b0, f_wb(2'b00));
    step(0, 1'b1, 1'b1, 1'b0, f_fetch(1'b1));

    // 13: bne without BRANCH_BNE -> illegal trap
    tnum = 13;
    step(1, 1'b0, 1'b1, 1'b0, f_rst());
    step(1, 1'b1, 1'b1, 1'b0, f_rst());
    step(1, 1'b1, 1'b1, 1'b0, f_fetch(1'b1));
    step(1, 1'b1, 1'b1, 1'b0, f_dec());
    for (int i = 0; i < 3; i++) step(1, 1'b1, 1'b1, 1'b0, f_trap(2'b01));

    @(posedge clk);
    @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control unit for the RV32I core: a registered state machine that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the shared-ALU datapath's enables and mux selects.
- Adds a wait-state memory handshake, optional `bne` support, a memory watchdog, a sticky trap state and a per-instruction retire pulse.
- Sits between the instruction register / ALU zero flag and the datapath muxes, PC, register file and unified memory port.

## Interface
- `BRANCH_BNE`, default 1: 1 = decode funct3 001 (`bne`) as a branch; 0 = only `beq` (funct3 000) is legal.
- `TIMEOUT_CYCLES`, default 16: trap after this many consecutive `mem_ready`-low cycles in one access; 0 disables the watchdog.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `inst` in 32: IR contents; valid from DECODE onward.
- `zero` in 1: ALU zero flag, combinational from the current ALU inputs.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write strobe; only ever high together with `mem_req`.
- `mem_addr_sel` out 1: memory address source; 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load IR and OldPC.
- `pc_write` out 1: PC write enable.
- `pc_src` out 2: next-PC source; 00 = ALU result, 01 = ALUOut register, 10 = ALU result & ~1.
- `alu_src_a` out 2: ALU A source; 00 = PC, 01 = OldPC, 10 = rs1.
- `alu_src_b` out 2: ALU B source; 00 = rs2, 01 = constant 4, 10 = immediate.
- `alu_op` out 2: 00 = add, 01 = branch compare, 10 = R-type funct, 11 = I-type funct.
- `reg_write` out 1: register-file write enable.
- `wb_sel` out 2: write-back source; 00 = ALUOut, 01 = MDR, 10 = OldPC+4.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `trap` out 1: sticky trap indicator.
- `trap_cause` out 2: 00 = none, 01 = illegal instruction, 10 = memory timeout.
- `state_o` out 3: current state encoding, for debug.

## Operation
States and encodings: RST = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, TRAP = 6.

All outputs are combinational from the state register and the latched class register only; `inst` is never decoded directly onto an output. Any output not listed for a state is 0.

- **RST:** all outputs 0. Always goes to FETCH on the next edge.
- **FETCH:** `mem_req`=1, `mem_addr_sel`=0, `alu_src_a`=00, `alu_src_b`=01, `alu_op`=00.
  - `mem_ready`=1: `ir_write`=1, `pc_write`=1 with `pc_src`=00; next state DECODE.
  - `mem_ready`=0: stay in FETCH.
- **DECODE:** `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00; the datapath captures the branch/jal target in ALUOut.
  - Latch the class from `inst[6:0]`/funct3: R (0110011), I (0010011), LOAD (0000011), STORE (0100011), BR (1100011 with funct3 000, or 001 when `BRANCH_BNE`=1), JAL (1101111), JALR (1100111).
  - Any other encoding: next state TRAP with cause 01. Otherwise next state EXEC.
- **EXEC:**
  - R: A=10, B=00, op=10; next WB.
  - I: A=10, B=10, op=11; next WB.
  - LOAD/STORE: A=10, B=10, op=00; next MEM.
  - BR: A=10, B=00, op=01, `pc_src`=01. `pc_write` = `zero` for beq, `!zero` for bne. `retire`=1; next FETCH.
  - JAL: `pc_write`=1, `pc_src`=01; next WB.
  - JALR: A=10, B=10, op=00, `pc_write`=1, `pc_src`=10; next WB.
- **MEM:** `mem_req`=1, `mem_addr_sel`=1, `mem_we` = (class==STORE).
  - Holds until `mem_ready`=1.
  - STORE completes with `retire`=1 and goes to FETCH; LOAD goes to WB (MDR is captured on `mem_ready`).
- **WB:** `reg_write`=1, `retire`=1; next FETCH.
  - `wb_sel`: 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
- **TRAP:** `trap`=1 and `trap_cause` held; all enables 0; left only by reset.
- **Watchdog** (only when `TIMEOUT_CYCLES`>0):
  - Counter of width $clog2(TIMEOUT_CYCLES+1), cleared on every entry to FETCH or MEM; increments each cycle in those states while `mem_ready`=0.
  - On the `TIMEOUT_CYCLES`-th consecutive low cycle, next state is TRAP with cause 10.

## Timing
- **Reset:** asynchronous `rst_n`=0 forces state RST, class R, counter 0 and `trap_cause` 00, with no clock required; every output reads 0, `state_o`=0. Reset asserted mid-instruction aborts it; no partial write-enable is left asserted.
- **Latency with zero-wait memory** (`mem_ready` held high): branch 3 cycles; R, I, store, JAL, JALR 4 cycles; load 5 cycles. Each wait cycle adds 1.
- **Handshake:** `mem_ready` is sampled only in FETCH and MEM and ignored in every other state. `mem_req` and the address select stay stable until completion.
- **Timeout tie:** if `mem_ready`=1 arrives on the `TIMEOUT_CYCLES`-th cycle, the access completes and no trap is raised.
- **`retire`:** exactly one pulse per instruction, in its final cycle; never asserted in TRAP.
- **Trap precedence:** an illegal instruction traps from DECODE with no `pc_write` or `reg_write` beyond the fetch-time PC+4 update.

## Test plan
- **Reset and start-up:** reset released, `mem_ready`=1, `inst`=add (0x002081B3) → `state_o` sequence 0,1,2,3,5,1; `reg_write`=1 and `retire`=1 in WB only.
- **Load with wait states:** `lw` (0x0000A103) with `mem_ready` low for 3 MEM cycles → MEM lasts 4 cycles, then WB with `wb_sel`=01; 8 cycles total from FETCH.
- **Branch outcome:** `beq` with `zero`=1 → `pc_write`=1 with `pc_src`=01 in EXEC, 3 cycles. `bne` with `zero`=1 → `pc_write`=0. `bne` with `BRANCH_BNE`=0 → TRAP, `trap_cause`=01.
- **Jumps:** JAL (0x0000006F) → EXEC `pc_write`=1 with `pc_src`=01, then WB with `wb_sel`=10. JALR (0x00008067) → `pc_src`=10.
- **Watchdog:** `TIMEOUT_CYCLES`=4 and `mem_ready` stuck low in FETCH → TRAP after exactly 4 cycles, cause 10. A variant with ready high on the 4th cycle → no trap.
- **Illegal opcode and reset recovery:** `inst`=0x00000000 → TRAP; it holds for 100 cycles with `retire`=0. Asserting `rst_n` mid-TRAP → all outputs 0 immediately; normal fetch resumes after release.
